pxs_cursor_ctrl: RTL and testbench

//  Upstream controller for the text-console cursor overlay stage. Accepts cursor

---
 rtl/pxs_pkg.sv | 49 ++++
 rtl/pxs_frame_tick.sv | 41 ++++
 rtl/pxs_cursor_ctrl.sv | 150 +++++++++++++++
 tb/tb_pxs_cursor_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pxs_pkg.sv
// rtl/pxs_pkg.sv - shared constants for the pixel-stream cursor blocks
// Purpose: RGB stream field offsets, cursor opcodes, tcursor bit indices,
//          controller state encoding and the tcursor packing helper.
// Ports:   none (package).
package pxs_pkg;

    // 26-bit RGB stream layout
    localparam int STR_W      = 26;
    localparam int STR_ACTIVE = 0;
    localparam int STR_VS     = 1;
    localparam int STR_HS     = 2;
    localparam int STR_YC_LO  = 3;
    localparam int STR_YC_HI  = 12;
    localparam int STR_XC_LO  = 13;
    localparam int STR_XC_HI  = 22;
    localparam int STR_RGB_LO = 23;
    localparam int STR_RGB_HI = 25;

    // Cursor command opcodes
    typedef enum logic [2:0] {
        CUR_NOP   = 3'd0,
        CUR_RIGHT = 3'd1,
        CUR_LEFT  = 3'd2,
        CUR_UP    = 3'd3,
        CUR_DOWN  = 3'd4,
        CUR_HOME  = 3'd5,
        CUR_SET   = 3'd6,
        CUR_TYPE  = 3'd7
    } cur_op_e;

    // tcursor bit indices
    localparam int TC_BLINK_EN = 0;
    localparam int TC_PHASE    = 1;
    localparam int TC_SHAPE_LO = 2;
    localparam int TC_SHAPE_HI = 3;

    // ST_HOLD is only reachable when the vsync-lock build option is enabled
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } ctrl_state_e;

    // Phase bit is masked by the blink enable so a disabled cursor stays solid
    function automatic logic [3:0] make_tcursor(input logic [3:0] type_r, input logic phase);
        return {type_r[3:2], type_r[0] & phase, type_r[0]};
    endfunction

endpackage

// File: rtl/pxs_frame_tick.sv
// rtl/pxs_frame_tick.sv - frame tick from VS rising edge plus blink phase divider
// Purpose: tick pulses for one cycle when VS goes 0->1 (VS registered once);
//          phase toggles every BLINK_FRAMES ticks.
// Ports:   px_clk, rst_n (async active-low), vs in; tick, phase out.
module pxs_frame_tick #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic px_clk,
    input  logic rst_n,
    input  logic vs,
    output logic tick,
    output logic phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             vs_q;
    logic [CNT_W-1:0] cnt;

    assign tick = vs & ~vs_q;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q  <= 1'b0;
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            vs_q <= vs;
            if (tick) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    phase <= ~phase;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pxs_cursor_ctrl.sv
// rtl/pxs_cursor_ctrl.sv - cursor command controller for the text overlay stage
// Purpose: accepts cursor commands over valid/ready, keeps (pos_x, pos_y)
//          inside a COLS x ROWS grid with wrap/clamp rules, and drives the
//          tcursor type/blink word. Build option CURSOR_VSYNC_LOCK_EN defers
//          every position/type update to the next frame tick (tear-free).
// Ports:   px_clk, rst_n (async active-low); RGBStr_i[25:0] (VS bit only);
//          cmd_valid/cmd_ready/cmd_op[2:0]/cmd_x[6:0]/cmd_y[6:0] command;
//          pos_x[6:0], pos_y[6:0], tcursor[3:0] outputs.
module pxs_cursor_ctrl
    import pxs_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 50,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic [25:0] RGBStr_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [6:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    output logic [6:0]  pos_x,
    output logic [6:0]  pos_y,
    output logic [3:0]  tcursor
);

    // Limits compared in 8 bits so x+1 / y+1 never overflow
    localparam logic [7:0] COLS_W = 8'(COLS);
    localparam logic [7:0] ROWS_W = 8'(ROWS);
    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [6:0] Y_LAST = 7'(ROWS - 1);

    ctrl_state_e state, state_nx;
    cur_op_e     op_q;
    logic [6:0]  x_q, y_q;
    logic [3:0]  type_q;
    logic        tick, phase;
    logic        xfer, commit;
    logic [6:0]  nx, ny;
    logic [3:0]  ntype;
    logic [7:0]  x_inc, y_inc;
    logic        unused_str;

    assign unused_str = ^{RGBStr_i[25:2], RGBStr_i[0]};

    pxs_frame_tick #(.BLINK_FRAMES(BLINK_FRAMES)) u_frame_tick (
        .px_clk (px_clk),
        .rst_n  (rst_n),
        .vs     (RGBStr_i[STR_VS]),
        .tick   (tick),
        .phase  (phase)
    );

    // Gated with rst_n so ready reads 0 for the whole reset assertion
    assign cmd_ready = rst_n && (state == ST_IDLE);
    assign xfer      = cmd_valid && cmd_ready;

    always_comb begin
        state_nx = state;
        commit   = 1'b0;
        case (state)
            ST_IDLE: if (xfer) state_nx = ST_EXEC;
`ifdef CURSOR_VSYNC_LOCK_EN
            ST_EXEC: state_nx = ST_HOLD;
            ST_HOLD: begin
                if (tick) begin
                    commit   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
`else
            ST_EXEC: begin
                commit   = 1'b1;
                state_nx = ST_IDLE;
            end
`endif
            default: state_nx = ST_IDLE;
        endcase
    end

    assign x_inc = {1'b0, pos_x} + 8'd1;
    assign y_inc = {1'b0, pos_y} + 8'd1;

    // Next position/type from the captured command; position does not move
    // between capture and commit, so this stays valid through HOLD.
    always_comb begin
        nx    = pos_x;
        ny    = pos_y;
        ntype = type_q;
        case (op_q)
            CUR_RIGHT: begin
                if (x_inc >= COLS_W) begin
                    nx = '0;
                    ny = (y_inc >= ROWS_W) ? 7'd0 : y_inc[6:0];
                end else begin
                    nx = x_inc[6:0];
                end
            end
            CUR_LEFT: begin
                if (pos_x == 7'd0) begin
                    nx = X_LAST;
                    ny = (pos_y == 7'd0) ? Y_LAST : pos_y - 7'd1;
                end else begin
                    nx = pos_x - 7'd1;
                end
            end
            CUR_UP:   ny = (pos_y == 7'd0) ? Y_LAST : pos_y - 7'd1;
            CUR_DOWN: ny = (y_inc >= ROWS_W) ? 7'd0 : y_inc[6:0];
            CUR_HOME: begin
                nx = '0;
                ny = '0;
            end
            CUR_SET: begin
                nx = ({1'b0, x_q} >= COLS_W) ? X_LAST : x_q;
                ny = ({1'b0, y_q} >= ROWS_W) ? Y_LAST : y_q;
            end
            CUR_TYPE: ntype = x_q[3:0];
            default: ;
        endcase
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            op_q   <= CUR_NOP;
            x_q    <= '0;
            y_q    <= '0;
            pos_x  <= '0;
            pos_y  <= '0;
            type_q <= '0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                op_q <= cur_op_e'(cmd_op);
                x_q  <= cmd_x;
                y_q  <= cmd_y;
            end
            if (commit) begin
                pos_x  <= nx;
                pos_y  <= ny;
                type_q <= ntype;
            end
        end
    end

    assign tcursor = make_tcursor(type_q, phase);

endmodule

// File: tb/tb_pxs_cursor_ctrl.sv
// tb/tb_pxs_cursor_ctrl.sv - self-checking bench for pxs_cursor_ctrl
module tb_pxs_cursor_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 50;
    localparam int BF   = 30;

    logic        px_clk = 1'b0;
    logic        rst_n;
    logic [25:0] RGBStr_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [6:0]  cmd_x;
    logic [6:0]  cmd_y;
    logic [6:0]  pos_x;
    logic [6:0]  pos_y;
    logic [3:0]  tcursor;

    int checks   = 0;
    int failures = 0;

    // Reference model state: cell, type word, number of frame ticks since reset
    int mx, my, mtype, mticks;

    pxs_cursor_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF)) dut (
        .px_clk    (px_clk),
        .rst_n     (rst_n),
        .RGBStr_i  (RGBStr_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .tcursor   (tcursor)
    );

    always #5 px_clk = ~px_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog sim_time=%0t limit=2000000", $time);
        $fatal(1);
    end

    function automatic void model_reset();
        mx = 0; my = 0; mtype = 0; mticks = 0;
    endfunction

    // Grid treated as a linear ring of COLS*ROWS cells for RIGHT/LEFT
    function automatic void model_cmd(input int op, input int x, input int y);
        int n, idx;
        n   = COLS * ROWS;
        idx = my * COLS + mx;
        case (op)
            1: begin idx = (idx + 1) % n;     mx = idx % COLS; my = idx / COLS; end
            2: begin idx = (idx + n - 1) % n; mx = idx % COLS; my = idx / COLS; end
            3: my = (my + ROWS - 1) % ROWS;
            4: my = (my + 1) % ROWS;
            5: begin mx = 0; my = 0; end
            6: begin mx = (x >= COLS) ? COLS - 1 : x; my = (y >= ROWS) ? ROWS - 1 : y; end
            7: mtype = x % 16;
            default: ;
        endcase
    endfunction

    function automatic logic [3:0] exp_tc();
        logic [3:0] t;
        logic       ph;
        t  = 4'(mtype);
        ph = ((mticks / BF) % 2) == 1;
        return {t[3:2], t[0] & ph, t[0]};
    endfunction

    task automatic vs_pulse();
        RGBStr_i        = 26'($urandom);
        RGBStr_i[1]     = 1'b1;
        @(negedge px_clk);
        RGBStr_i[1]     = 1'b0;
        @(negedge px_clk);
        mticks++;
    endtask

    task automatic send_cmd(input int op, input int x, input int y);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge px_clk);
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL send_cmd_timeout cmd_ready=%b required=1", cmd_ready);
        end
        cmd_op = 3'(op); cmd_x = 7'(x); cmd_y = 7'(y); cmd_valid = 1'b1;
        @(negedge px_clk);
        cmd_valid = 1'b0;
`ifdef CURSOR_VSYNC_LOCK_EN
        @(negedge px_clk);
        vs_pulse();
`endif
        @(negedge px_clk);
        model_cmd(op, x, y);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge px_clk);
        rst_n = 1'b1;
        @(negedge px_clk);
        model_reset();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge px_clk);
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", cmd_ready); end
        checks++; if (pos_x !== 7'd0 || pos_y !== 7'd0) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(0,0)", pos_x, pos_y); end
        checks++; if (tcursor !== 4'd0) begin failures++; $display("FAIL reset_tcursor got=%b exp=0000", tcursor); end
        rst_n = 1'b1;
        @(negedge px_clk);
        model_reset();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", cmd_ready); end
        send_cmd(6, 7, 3);
        send_cmd(7, 13, 0);
        checks++; if (pos_x !== 7'(mx) || pos_y !== 7'(my)) begin failures++; $display("FAIL pre_reset_pos got=(%0d,%0d) exp=(%0d,%0d)", pos_x, pos_y, mx, my); end
        checks++; if (tcursor !== exp_tc()) begin failures++; $display("FAIL pre_reset_tc got=%b exp=%b", tcursor, exp_tc()); end
        cmd_op = 3'd6; cmd_x = 7'd20; cmd_y = 7'd20; cmd_valid = 1'b1;
        @(negedge px_clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (pos_x !== 7'd0 || pos_y !== 7'd0 || tcursor !== 4'd0) begin failures++; $display("FAIL midcmd_reset got=(%0d,%0d,%b) exp=(0,0,0000)", pos_x, pos_y, tcursor); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL midcmd_reset_ready got=%b exp=0", cmd_ready); end
        @(negedge px_clk);
        rst_n = 1'b1;
        @(negedge px_clk);
        checks++; if (cmd_ready !== 1'b1 || pos_x !== 7'd0 || pos_y !== 7'd0) begin failures++; $display("FAIL midcmd_release got=rdy%b (%0d,%0d) exp=rdy1 (0,0)", cmd_ready, pos_x, pos_y); end
    endtask

    task automatic test_wrap();
        send_cmd(5, 0, 0);
        for (int i = 0; i < 79; i++) send_cmd(1, 0, 0);
        checks++; if (pos_x !== 7'd79 || pos_y !== 7'd0) begin failures++; $display("FAIL right79 got=(%0d,%0d) exp=(79,0)", pos_x, pos_y); end
        send_cmd(1, 0, 0);
        checks++; if (pos_x !== 7'd0 || pos_y !== 7'd1) begin failures++; $display("FAIL right_wrap_row got=(%0d,%0d) exp=(0,1)", pos_x, pos_y); end
        send_cmd(6, 79, 49);
        send_cmd(1, 0, 0);
        checks++; if (pos_x !== 7'd0 || pos_y !== 7'd0) begin failures++; $display("FAIL right_wrap_corner got=(%0d,%0d) exp=(0,0)", pos_x, pos_y); end
        send_cmd(2, 0, 0);
        checks++; if (pos_x !== 7'd79 || pos_y !== 7'd49) begin failures++; $display("FAIL left_wrap_corner got=(%0d,%0d) exp=(79,49)", pos_x, pos_y); end
        send_cmd(6, 0, 7);
        send_cmd(2, 0, 0);
        checks++; if (pos_x !== 7'd79 || pos_y !== 7'd6) begin failures++; $display("FAIL left_wrap_row got=(%0d,%0d) exp=(79,6)", pos_x, pos_y); end
    endtask

    task automatic test_set_updown();
        send_cmd(6, 100, 60);
        checks++; if (pos_x !== 7'd79 || pos_y !== 7'd49) begin failures++; $display("FAIL set_clamp got=(%0d,%0d) exp=(79,49)", pos_x, pos_y); end
        send_cmd(6, 33, 0);
        send_cmd(3, 0, 0);
        checks++; if (pos_x !== 7'd33 || pos_y !== 7'd49) begin failures++; $display("FAIL up_wrap got=(%0d,%0d) exp=(33,49)", pos_x, pos_y); end
        send_cmd(4, 0, 0);
        checks++; if (pos_x !== 7'd33 || pos_y !== 7'd0) begin failures++; $display("FAIL down_wrap got=(%0d,%0d) exp=(33,0)", pos_x, pos_y); end
        send_cmd(4, 0, 0);
        checks++; if (pos_x !== 7'd33 || pos_y !== 7'd1) begin failures++; $display("FAIL down_step got=(%0d,%0d) exp=(33,1)", pos_x, pos_y); end
    endtask

    task automatic test_blink();
        logic [3:0] e;
        do_reset();
        send_cmd(7, 1, 0);
        for (int p = 1; p <= 61; p++) begin
            vs_pulse();
            e = exp_tc();
            checks++; if (tcursor !== e) begin failures++; $display("FAIL blink_pulse%0d got=%b exp=%b", p, tcursor, e); end
        end
        send_cmd(7, 0, 0);
        checks++; if (tcursor !== 4'd0) begin failures++; $display("FAIL blink_off got=%b exp=0000", tcursor); end
        for (int p = 0; p < 30; p++) vs_pulse();
        checks++; if (tcursor[1] !== 1'b0) begin failures++; $display("FAIL blink_off_phase got=%b exp=0", tcursor[1]); end
        send_cmd(7, 1, 0);
        e = exp_tc();
        checks++; if (tcursor !== e) begin failures++; $display("FAIL blink_resume got=%b exp=%b", tcursor, e); end
    endtask

    task automatic test_back_to_back();
`ifndef CURSOR_VSYNC_LOCK_EN
        int xf;
        send_cmd(5, 0, 0);
        xf = 0;
        cmd_op = 3'd1; cmd_x = 7'd0; cmd_y = 7'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (cmd_ready !== ((i % 2) == 0)) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, cmd_ready, (i % 2) == 0); end
            if (cmd_ready === 1'b1) xf++;
            @(negedge px_clk);
        end
        cmd_valid = 1'b0;
        mx = 4; my = 0;
        checks++; if (xf !== 4) begin failures++; $display("FAIL b2b_transfers got=%0d exp=4", xf); end
        checks++; if (pos_x !== 7'd4 || pos_y !== 7'd0) begin failures++; $display("FAIL b2b_pos got=(%0d,%0d) exp=(4,0)", pos_x, pos_y); end
        repeat (3) @(negedge px_clk);
        checks++; if (pos_x !== 7'd4) begin failures++; $display("FAIL b2b_settle got=%0d exp=4", pos_x); end
`endif
    endtask

    task automatic test_vsync_lock();
`ifdef CURSOR_VSYNC_LOCK_EN
        int ox, oy;
        send_cmd(6, 3, 3);
        ox = mx; oy = my;
        cmd_op = 3'd6; cmd_x = 7'd10; cmd_y = 7'd5; cmd_valid = 1'b1;
        @(negedge px_clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge px_clk);
            checks++; if (pos_x !== 7'(ox) || pos_y !== 7'(oy) || cmd_ready !== 1'b0) begin failures++; $display("FAIL lock_hold%0d got=(%0d,%0d) rdy=%b exp=(%0d,%0d) rdy=0", i, pos_x, pos_y, cmd_ready, ox, oy); end
        end
        vs_pulse();
        model_cmd(6, 10, 5);
        checks++; if (pos_x !== 7'd10 || pos_y !== 7'd5 || cmd_ready !== 1'b1) begin failures++; $display("FAIL lock_commit got=(%0d,%0d) rdy=%b exp=(10,5) rdy=1", pos_x, pos_y, cmd_ready); end
`endif
    endtask

    task automatic test_random();
        int op, x, y;
        logic [3:0] e;
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: x = 0;
                1: x = COLS - 1;
                default: x = int'($urandom_range(0, 127));
            endcase
            case ($urandom_range(0, 3))
                0: y = 0;
                1: y = ROWS - 1;
                default: y = int'($urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 2) == 0) vs_pulse();
            send_cmd(op, x, y);
            e = exp_tc();
            checks++; if (pos_x !== 7'(mx) || pos_y !== 7'(my) || tcursor !== e) begin
                failures++;
                $display("FAIL random%0d op=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,%b)", i, op, pos_x, pos_y, tcursor, mx, my, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; RGBStr_i = '0;
        model_reset();
        test_reset();
        test_wrap();
        test_set_updown();
        test_blink();
        test_back_to_back();
        test_vsync_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
